// File: rtl/mem_arbiter.sv
// Shares one memory bus between instruction fetch and data access, one transaction in flight.
// Data wins ties; a starvation counter forces a fetch grant after STARVE_MAX back-to-back data wins.
module mem_arbiter #(
    parameter int unsigned VLEN       = 64,
    parameter int unsigned DLEN       = 64,
    parameter int unsigned ILEN       = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    // Fetch port
    input  logic            i_req,
    input  logic [VLEN-1:0] i_addr,
    output logic            i_gnt,
    output logic            i_valid,
    output logic [ILEN-1:0] i_data,
    // Data port
    input  logic            d_req,
    input  logic            d_we,
    input  logic [VLEN-1:0] d_addr,
    input  logic [DLEN-1:0] d_wdata,
    input  logic [1:0]      d_len,
    output logic            d_gnt,
    output logic            d_valid,
    output logic [DLEN-1:0] d_rdata,
    // Memory bus
    output logic            m_req,
    output logic            m_we,
    output logic [VLEN-1:0] m_addr,
    output logic [DLEN-1:0] m_wdata,
    output logic [1:0]      m_len,
    input  logic            m_ack,
    input  logic [DLEN-1:0] m_rdata
);

    typedef enum logic [1:0] {
        StIdle,
        StBusyI,
        StBusyD
    } state_e;

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    state_e          r_state, w_state_next;
    logic [3:0]      r_starve, w_starve_next;
    logic            w_gnt_i, w_gnt_d;

    logic            r_m_req, r_m_we, r_i_valid, r_d_valid;
    logic [VLEN-1:0] r_m_addr;
    logic [DLEN-1:0] r_m_wdata, r_d_rdata;
    logic [1:0]      r_m_len;
    logic [ILEN-1:0] r_i_data;

    // Grants are gated by reset so nothing is accepted while rst is asserted.
    always_comb begin
        w_gnt_i = 1'b0;
        w_gnt_d = 1'b0;
        if (rst && (r_state == StIdle)) begin
            if (d_req && !(i_req && (r_starve == StarveMax))) begin
                w_gnt_d = 1'b1;
            end else if (i_req) begin
                w_gnt_i = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_gnt_d) begin
                    w_state_next = StBusyD;
                end else if (w_gnt_i) begin
                    w_state_next = StBusyI;
                end
            end
            StBusyI, StBusyD: begin
                if (m_ack) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Counts data wins while fetch is waiting; any fetch grant or idle fetch port clears it.
    always_comb begin
        w_starve_next = r_starve;
        if (!i_req || w_gnt_i) begin
            w_starve_next = 4'd0;
        end else if (w_gnt_d && (r_starve < StarveMax)) begin
            w_starve_next = r_starve + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= StIdle;
            r_starve <= 4'd0;
        end else begin
            r_state  <= w_state_next;
            r_starve <= w_starve_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m_req   <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_m_len   <= 2'b00;
            r_i_valid <= 1'b0;
            r_d_valid <= 1'b0;
            r_i_data  <= '0;
            r_d_rdata <= '0;
        end else begin
            r_i_valid <= 1'b0;
            r_d_valid <= 1'b0;
            if (w_gnt_d) begin
                r_m_req   <= 1'b1;
                r_m_we    <= d_we;
                r_m_addr  <= d_addr;
                r_m_wdata <= d_wdata;
                r_m_len   <= d_len;
            end else if (w_gnt_i) begin
                r_m_req   <= 1'b1;
                r_m_we    <= 1'b0;
                r_m_addr  <= i_addr;
                r_m_wdata <= '0;
                r_m_len   <= 2'b10;
            end else if (m_ack && (r_state != StIdle)) begin
                r_m_req <= 1'b0;
                if (r_state == StBusyI) begin
                    r_i_valid <= 1'b1;
                    r_i_data  <= m_rdata[ILEN-1:0];
                end else begin
                    r_d_valid <= 1'b1;
                    r_d_rdata <= m_rdata;
                end
            end
        end
    end

    assign i_gnt   = w_gnt_i;
    assign d_gnt   = w_gnt_d;
    assign i_valid = r_i_valid;
    assign d_valid = r_d_valid;
    assign i_data  = r_i_data;
    assign d_rdata = r_d_rdata;
    assign m_req   = r_m_req;
    assign m_we    = r_m_we;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign m_len   = r_m_len;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a simple fixed-latency memory responder.
module tb_mem_arbiter;

    localparam int unsigned VLEN = 64;
    localparam int unsigned DLEN = 64;
    localparam int unsigned ILEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            i_req, i_gnt, i_valid;
    logic [VLEN-1:0] i_addr;
    logic [ILEN-1:0] i_data;
    logic            d_req, d_we, d_gnt, d_valid;
    logic [VLEN-1:0] d_addr;
    logic [DLEN-1:0] d_wdata, d_rdata;
    logic [1:0]      d_len;
    logic            m_req, m_we, m_ack;
    logic [VLEN-1:0] m_addr;
    logic [DLEN-1:0] m_wdata, m_rdata;
    logic [1:0]      m_len;

    int          total = 0;
    int          bad   = 0;
    int          mem_wait = 0;
    int          mem_cnt;
    logic        spurious = 1'b0;
    logic [63:0] mem_data = '0;
    logic        seen_i, seen_d;

    mem_arbiter #(
        .VLEN       (VLEN),
        .DLEN       (DLEN),
        .ILEN       (ILEN),
        .STARVE_MAX (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_gnt   (i_gnt),
        .i_valid (i_valid),
        .i_data  (i_data),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_len   (d_len),
        .d_gnt   (d_gnt),
        .d_valid (d_valid),
        .d_rdata (d_rdata),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_len   (m_len),
        .m_ack   (m_ack),
        .m_rdata (m_rdata)
    );

    always #5 clk = ~clk;

    // Memory acks after mem_wait cycles of m_req; spurious forces ack regardless.
    assign m_ack   = spurious | (m_req & (mem_cnt == mem_wait));
    assign m_rdata = mem_data;

    always @(posedge clk or negedge rst) begin
        if (!rst) mem_cnt <= 0;
        else      mem_cnt <= (m_req && !m_ack) ? mem_cnt + 1 : 0;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        i_req = 0; i_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_len = 2'b00;

        // Reset state
        #2;
        i_req = 1;
        #1;
        check_eq("rst_i_gnt", i_gnt, 0);
        check_eq("rst_m_req", m_req, 0);
        check_eq("rst_valids", {i_valid, d_valid}, 0);
        check_eq("rst_m_addr", m_addr, 0);
        check_eq("rst_d_rdata", d_rdata, 0);
        check_eq("rst_i_data", i_data, 0);
        i_req = 0;
        step(); step();
        rst = 1;
        step();

        // Single fetch, ack 2 cycles after m_req
        i_req = 1; i_addr = 64'h100; mem_wait = 2; mem_data = 64'h0000_0000_DEAD_BEEF;
        settle();
        check_eq("fetch_gnt", {i_gnt, d_gnt}, 2'b10);
        step(); i_req = 0; settle();
        check_eq("fetch_m_req", m_req, 1);
        check_eq("fetch_m_addr", m_addr, 64'h100);
        check_eq("fetch_m_len", m_len, 2'b10);
        check_eq("fetch_m_we", m_we, 0);
        step(); settle();
        check_eq("fetch_c2_valid", i_valid, 0);
        step(); settle();
        check_eq("fetch_c3_hold", {m_req, i_valid}, 2'b10);
        step(); settle();
        check_eq("fetch_valid", i_valid, 1);
        check_eq("fetch_data", i_data, 32'hDEAD_BEEF);
        check_eq("fetch_m_req_drop", m_req, 0);
        step(); settle();
        check_eq("fetch_pulse_end", i_valid, 0);
        check_eq("fetch_data_hold", i_data, 32'hDEAD_BEEF);

        // Store, zero-wait
        step();
        d_req = 1; d_we = 1; d_addr = 64'h2000; d_wdata = 64'h1122_3344_5566_7788;
        d_len = 2'b11; mem_wait = 0;
        settle();
        check_eq("store_gnt", {i_gnt, d_gnt}, 2'b01);
        step(); d_req = 0; settle();
        check_eq("store_m_req", m_req, 1);
        check_eq("store_m_we", m_we, 1);
        check_eq("store_m_addr", m_addr, 64'h2000);
        check_eq("store_m_wdata", m_wdata, 64'h1122_3344_5566_7788);
        check_eq("store_m_len", m_len, 2'b11);
        step(); settle();
        check_eq("store_valid", d_valid, 1);
        step(); settle();
        check_eq("store_pulse_end", d_valid, 0);

        // Priority: both requests together, data first
        step();
        i_req = 1; i_addr = 64'h400; d_req = 1; d_we = 0; d_addr = 64'h3000; d_len = 2'b10;
        mem_data = 64'hAABB_CCDD_0102_0304;
        settle();
        check_eq("prio_gnt", {i_gnt, d_gnt}, 2'b01);
        step(); d_req = 0; settle();
        check_eq("prio_busy_nogrant", {i_gnt, d_gnt}, 2'b00);
        step(); settle();
        check_eq("prio_d_valid", d_valid, 1);
        check_eq("prio_d_rdata", d_rdata, 64'hAABB_CCDD_0102_0304);
        check_eq("prio_i_gnt_same_cycle", {i_gnt, d_gnt}, 2'b10);
        step(); i_req = 0;
        step(); settle();
        check_eq("prio_i_valid", i_valid, 1);
        check_eq("prio_i_data", i_data, 32'h0102_0304);

        // Starvation: both held high, zero-wait memory
        step();
        i_req = 1; d_req = 1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) step();
            settle();
            check_eq($sformatf("starve_c%0d", c), {i_gnt, d_gnt},
                     (c % 2 == 1) ? 2'b00 : ((c == 8) ? 2'b10 : 2'b01));
        end
        step(); i_req = 0; d_req = 0;
        step(); step();

        // Spurious ack while idle
        spurious = 1;
        for (int c = 0; c < 3; c++) begin
            settle();
            check_eq($sformatf("spur_c%0d", c), {m_req, i_valid, d_valid}, 3'b000);
            step();
        end
        spurious = 0;
        i_req = 1; i_addr = 64'h300; mem_wait = 1; mem_data = 64'h0000_0000_CAFE_F00D;
        settle();
        check_eq("spur_fetch_gnt", {i_gnt, d_gnt}, 2'b10);
        step(); i_req = 0;
        step();
        step(); settle();
        check_eq("spur_fetch_valid", i_valid, 1);
        check_eq("spur_fetch_data", i_data, 32'hCAFE_F00D);

        // Reset while BUSY_D
        step();
        d_req = 1; d_we = 0; d_addr = 64'h40; d_len = 2'b11; mem_wait = 20;
        settle();
        check_eq("rstmid_d_gnt", d_gnt, 1);
        step(); d_req = 0; settle();
        check_eq("rstmid_m_req_before", m_req, 1);
        step();
        rst = 0; i_req = 1;
        #1;
        check_eq("rstmid_m_req", m_req, 0);
        check_eq("rstmid_m_addr", m_addr, 0);
        check_eq("rstmid_i_gnt", i_gnt, 0);
        step();
        mem_wait = 1; mem_data = 64'h0000_0000_1234_5678;
        rst = 1;
        settle();
        check_eq("rstrel_i_gnt", {i_gnt, d_gnt}, 2'b10);
        seen_i = 0; seen_d = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            i_req = 0;
            settle();
            if (i_valid) seen_i = 1;
            if (d_valid) seen_d = 1;
        end
        check_eq("rstrel_no_d_valid", seen_d, 0);
        check_eq("rstrel_i_valid", seen_i, 1);
        check_eq("rstrel_i_data", i_data, 32'h1234_5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
